// File: rtl/vx_scoreboard.sv
// vx_scoreboard: per-warp register in-use table guarding issue against
// RAW/WAW hazards. An instruction at the buffer head is offered to dispatch
// only when none of its registers (rd, rs1, rs2, rs3) is marked in use for
// its warp. Issue of a writing instruction marks rd; the last (eop) beat of
// its writeback releases it one cycle later. Register 0 is never tracked.
//
// Optional feature: define SCOREBOARD_PERF_EN to build the saturating
// hazard-stall counter behind perf_stalls; otherwise perf_stalls is tied 0.
module vx_scoreboard #(
    parameter  int NUM_WARPS = 4,
    parameter  int NUM_REGS  = 64,
    localparam int WIDW      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int NRW       = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 ibuf_valid,
    input  logic [WIDW-1:0]      ibuf_wid,
    input  logic                 ibuf_wb,
    input  logic [NRW-1:0]       ibuf_rd,
    input  logic [NRW-1:0]       ibuf_rs1,
    input  logic [NRW-1:0]       ibuf_rs2,
    input  logic [NRW-1:0]       ibuf_rs3,
    output logic                 ibuf_ready,

    output logic                 issue_valid,
    input  logic                 issue_ready,

    input  logic                 wb_valid,
    input  logic [WIDW-1:0]      wb_wid,
    input  logic [NRW-1:0]       wb_rd,
    input  logic                 wb_eop,

    output logic [NUM_WARPS-1:0] warp_busy,
    output logic [31:0]          perf_stalls
);

    logic [NUM_REGS-1:0]  inuse_q [NUM_WARPS];
    logic [NUM_REGS-1:0]  inuse_d [NUM_WARPS];
    logic [NUM_WARPS-1:0] warp_busy_q;
    logic [NUM_WARPS-1:0] warp_busy_d;

    logic hazard_s;
    logic fire_s;
    logic set_en_s;
    logic clr_en_s;

    // Hazard lookup reads only the registered table: a writeback in this
    // cycle does not bypass, so release is visible one cycle after its edge.
    assign hazard_s = ibuf_valid &&
                      (inuse_q[ibuf_wid][ibuf_rd]  ||
                       inuse_q[ibuf_wid][ibuf_rs1] ||
                       inuse_q[ibuf_wid][ibuf_rs2] ||
                       inuse_q[ibuf_wid][ibuf_rs3]);

    assign issue_valid = ibuf_valid && !hazard_s;
    assign ibuf_ready  = issue_ready && !hazard_s;
    assign fire_s      = issue_valid && issue_ready;

    // Register 0 is hardwired free, so neither set nor clear ever targets it.
    assign set_en_s = fire_s && ibuf_wb && (ibuf_rd != {NRW{1'b0}});
    assign clr_en_s = wb_valid && wb_eop && (wb_rd != {NRW{1'b0}});

    // Next table state: reset wipes everything; otherwise a set overrides a
    // clear of the same entry, and a clear of another entry still applies.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            inuse_d[w] = inuse_q[w];
        end
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                inuse_d[w] = {NUM_REGS{1'b0}};
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    inuse_d[w][r] =
                        (set_en_s && (ibuf_wid == WIDW'(w)) && (ibuf_rd == NRW'(r))) ? 1'b1 :
                        (clr_en_s && (wb_wid == WIDW'(w)) && (wb_rd == NRW'(r)))     ? 1'b0 :
                        inuse_q[w][r];
                end
            end
        end
    end

    // Per-warp busy summary, computed from the next table so the registered
    // copy always matches the table contents of the same cycle.
    always_comb begin
        warp_busy_d = {NUM_WARPS{1'b0}};
        for (int w = 0; w < NUM_WARPS; w++) begin
            warp_busy_d[w] = |inuse_d[w];
        end
    end

    // Table and busy-summary registers.
    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            inuse_q[w] <= inuse_d[w];
        end
        warp_busy_q <= warp_busy_d;
    end

    assign warp_busy = warp_busy_q;

`ifdef SCOREBOARD_PERF_EN
    logic [31:0] perf_stalls_q;
    logic [31:0] perf_stalls_d;

    // Stall counter: one count per non-reset cycle spent on a hazard, held
    // at all-ones instead of wrapping.
    always_comb begin
        perf_stalls_d = perf_stalls_q;
        if (reset) begin
            perf_stalls_d = 32'd0;
        end else if (hazard_s && (perf_stalls_q != 32'hFFFF_FFFF)) begin
            perf_stalls_d = perf_stalls_q + 32'd1;
        end else begin
            perf_stalls_d = perf_stalls_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        perf_stalls_q <= perf_stalls_d;
    end

    assign perf_stalls = perf_stalls_q;
`else
    assign perf_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_vx_scoreboard.sv
// Directed bench for vx_scoreboard (default parameters: 4 warps, 64 regs).
module tb_vx_scoreboard;

    logic       clk;
    logic       reset;
    logic       ibuf_valid;
    logic [1:0] ibuf_wid;
    logic       ibuf_wb;
    logic [5:0] ibuf_rd;
    logic [5:0] ibuf_rs1;
    logic [5:0] ibuf_rs2;
    logic [5:0] ibuf_rs3;
    logic       ibuf_ready;
    logic       issue_valid;
    logic       issue_ready;
    logic       wb_valid;
    logic [1:0] wb_wid;
    logic [5:0] wb_rd;
    logic       wb_eop;
    logic [3:0] warp_busy;
    logic [31:0] perf_stalls;

    int checks;
    int failures;

    vx_scoreboard #(.NUM_WARPS(4), .NUM_REGS(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .ibuf_valid  (ibuf_valid),
        .ibuf_wid    (ibuf_wid),
        .ibuf_wb     (ibuf_wb),
        .ibuf_rd     (ibuf_rd),
        .ibuf_rs1    (ibuf_rs1),
        .ibuf_rs2    (ibuf_rs2),
        .ibuf_rs3    (ibuf_rs3),
        .ibuf_ready  (ibuf_ready),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .wb_valid    (wb_valid),
        .wb_wid      (wb_wid),
        .wb_rd       (wb_rd),
        .wb_eop      (wb_eop),
        .warp_busy   (warp_busy),
        .perf_stalls (perf_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance past the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input logic v, input logic [1:0] wid, input logic wb,
                        input logic [5:0] rd, input logic [5:0] rs1,
                        input logic [5:0] rs2, input logic [5:0] rs3);
        ibuf_valid = v; ibuf_wid = wid; ibuf_wb = wb;
        ibuf_rd = rd; ibuf_rs1 = rs1; ibuf_rs2 = rs2; ibuf_rs3 = rs3;
    endtask

    task automatic wb(input logic v, input logic [1:0] wid, input logic [5:0] rd, input logic eop);
        wb_valid = v; wb_wid = wid; wb_rd = rd; wb_eop = eop;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        issue_ready = 1'b1;
        head(1'b0, 2'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
        wb(1'b0, 2'd0, 6'd0, 1'b0);
        tick();
        // fire attempt while reset is high must be ignored
        head(1'b1, 2'd0, 1'b1, 6'd9, 6'd0, 6'd0, 6'd0);
        tick();
        tick();
        check("rst_busy", 32'(warp_busy), 32'd0);
        check("rst_perf", perf_stalls, 32'd0);
        check("rst_ready", 32'(ibuf_ready), 32'd1);
        reset = 1'b0;
        head(1'b1, 2'd0, 1'b0, 6'd0, 6'd9, 6'd0, 6'd0);
        #1;
        check("rst_fire_ignored", 32'(issue_valid), 32'd1);
        tick();
        check("rst_fire_busy", 32'(warp_busy), 32'd0);

        // RAW on same warp, release one cycle after eop writeback
        head(1'b1, 2'd1, 1'b1, 6'd5, 6'd0, 6'd0, 6'd0);
        #1;
        check("w1_issue_valid", 32'(issue_valid), 32'd1);
        tick();
        head(1'b1, 2'd1, 1'b0, 6'd0, 6'd5, 6'd0, 6'd0);
        #1;
        check("raw_valid", 32'(issue_valid), 32'd0);
        check("raw_ready", 32'(ibuf_ready), 32'd0);
        check("raw_busy", 32'(warp_busy), 32'h2);
        wb(1'b1, 2'd1, 6'd5, 1'b1);
        #1;
        check("no_bypass", 32'(issue_valid), 32'd0);
        tick();
        wb(1'b0, 2'd0, 6'd0, 1'b0);
        #1;
        check("release_valid", 32'(issue_valid), 32'd1);
        check("release_busy", 32'(warp_busy), 32'd0);

        // per-warp isolation
        head(1'b1, 2'd0, 1'b1, 6'd5, 6'd0, 6'd0, 6'd0);
        tick();
        head(1'b1, 2'd2, 1'b0, 6'd0, 6'd0, 6'd5, 6'd0);
        #1;
        check("iso_valid", 32'(issue_valid), 32'd1);
        check("iso_busy", 32'(warp_busy), 32'h1);
        head(1'b1, 2'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd5);
        #1;
        check("rs3_hazard", 32'(issue_valid), 32'd0);
        head(1'b0, 2'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
        wb(1'b1, 2'd0, 6'd5, 1'b1);
        tick();
        wb(1'b0, 2'd0, 6'd0, 1'b0);

        // rd=0 is never tracked
        head(1'b1, 2'd2, 1'b1, 6'd0, 6'd0, 6'd0, 6'd0);
        tick();
        check("r0_busy", 32'(warp_busy), 32'd0);
        head(1'b1, 2'd2, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
        #1;
        check("r0_valid", 32'(issue_valid), 32'd1);
        check("r0_ready", 32'(ibuf_ready), 32'd1);

        // dispatch not ready: no fire, no set
        issue_ready = 1'b0;
        head(1'b1, 2'd2, 1'b1, 6'd11, 6'd0, 6'd0, 6'd0);
        #1;
        check("nordy_valid", 32'(issue_valid), 32'd1);
        check("nordy_ready", 32'(ibuf_ready), 32'd0);
        tick();
        check("nordy_busy", 32'(warp_busy), 32'd0);
        issue_ready = 1'b1;

        // same-cycle set and clear of w3/r7: set wins
        head(1'b1, 2'd3, 1'b1, 6'd7, 6'd0, 6'd0, 6'd0);
        wb(1'b1, 2'd3, 6'd7, 1'b1);
        tick();
        wb(1'b0, 2'd0, 6'd0, 1'b0);
        head(1'b1, 2'd3, 1'b0, 6'd0, 6'd7, 6'd0, 6'd0);
        #1;
        check("setwins_busy", 32'(warp_busy), 32'h8);
        check("setwins_hazard", 32'(issue_valid), 32'd0);
        // set r9 while clearing r7 of the same warp: both apply
        head(1'b1, 2'd3, 1'b1, 6'd9, 6'd0, 6'd0, 6'd0);
        wb(1'b1, 2'd3, 6'd7, 1'b1);
        tick();
        wb(1'b0, 2'd0, 6'd0, 1'b0);
        head(1'b1, 2'd3, 1'b0, 6'd0, 6'd7, 6'd0, 6'd0);
        #1;
        check("indep_clear", 32'(issue_valid), 32'd1);
        head(1'b1, 2'd3, 1'b0, 6'd0, 6'd0, 6'd9, 6'd0);
        #1;
        check("indep_set", 32'(issue_valid), 32'd0);
        head(1'b0, 2'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
        wb(1'b1, 2'd3, 6'd9, 1'b1);
        tick();
        wb(1'b0, 2'd0, 6'd0, 1'b0);
        check("indep_busy", 32'(warp_busy), 32'd0);

        // non-eop beat holds, eop beat releases
        head(1'b1, 2'd1, 1'b1, 6'd5, 6'd0, 6'd0, 6'd0);
        tick();
        head(1'b1, 2'd1, 1'b0, 6'd0, 6'd5, 6'd0, 6'd0);
        wb(1'b1, 2'd1, 6'd5, 1'b0);
        tick();
        check("noeop_valid", 32'(issue_valid), 32'd0);
        check("noeop_busy", 32'(warp_busy), 32'h2);
        wb(1'b1, 2'd1, 6'd5, 1'b1);
        tick();
        wb(1'b0, 2'd0, 6'd0, 1'b0);
        check("eop_valid", 32'(issue_valid), 32'd1);

        // writeback of a free register is harmless
        head(1'b0, 2'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
        wb(1'b1, 2'd2, 6'd12, 1'b1);
        tick();
        wb(1'b0, 2'd0, 6'd0, 1'b0);
        check("stray_wb_busy", 32'(warp_busy), 32'd0);

        // reset mid-operation clears table and drops pending writes
        head(1'b1, 2'd0, 1'b1, 6'd3, 6'd0, 6'd0, 6'd0);
        tick();
        head(1'b1, 2'd2, 1'b1, 6'd4, 6'd0, 6'd0, 6'd0);
        tick();
        check("pre_rst_busy", 32'(warp_busy), 32'h5);
        reset = 1'b1;
        head(1'b1, 2'd1, 1'b1, 6'd6, 6'd0, 6'd0, 6'd0);
        wb(1'b1, 2'd0, 6'd3, 1'b1);
        tick();
        reset = 1'b0;
        wb(1'b0, 2'd0, 6'd0, 1'b0);
        check("mid_rst_busy", 32'(warp_busy), 32'd0);
        head(1'b1, 2'd0, 1'b0, 6'd0, 6'd3, 6'd0, 6'd0);
        #1;
        check("mid_rst_valid", 32'(issue_valid), 32'd1);
        head(1'b1, 2'd1, 1'b0, 6'd0, 6'd6, 6'd0, 6'd0);
        #1;
        check("rst_drop_fire", 32'(issue_valid), 32'd1);

        // stall counting over 10 cycles, then reset mid-stall
        head(1'b0, 2'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        head(1'b1, 2'd1, 1'b1, 6'd5, 6'd0, 6'd0, 6'd0);
        tick();
        head(1'b1, 2'd1, 1'b0, 6'd0, 6'd5, 6'd0, 6'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
        end
`ifdef SCOREBOARD_PERF_EN
        check("perf_10", perf_stalls, 32'd10);
`else
        check("perf_tied", perf_stalls, 32'd0);
`endif
        check("stall_busy", 32'(warp_busy), 32'h2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("perf_rst", perf_stalls, 32'd0);
        check("perf_rst_busy", 32'(warp_busy), 32'd0);
        #1;
        check("post_rst_valid", 32'(issue_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vx_scoreboard.md
VX_SCOREBOARD -- requirements
Module: VX_scoreboard

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, number of hardware warps; WIDW = max(1, clog2(NUM_WARPS)).
REQ-002 SHALL have parameter NUM_REGS, default 64, architectural registers (32 integer + 32 FP); NRW = clog2(NUM_REGS).
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ibuf_valid  input  1  instruction-buffer head valid.
REQ-006 SHALL have port ibuf_wid  input  WIDW  warp of head instruction.
REQ-007 SHALL have port ibuf_wb  input  1  head instruction writes rd.
REQ-008 SHALL have ports ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3  input  NRW each  head register indices.
REQ-009 SHALL have port ibuf_ready  output  1  head consumed this cycle.
REQ-010 SHALL have port issue_valid  output  1  hazard-free instruction offered to dispatch.
REQ-011 SHALL have port issue_ready  input  1  dispatch accepts.
REQ-012 SHALL have ports wb_valid  input  1, wb_wid  input  WIDW, wb_rd  input  NRW, wb_eop  input  1  writeback commit; eop marks last beat.
REQ-013 SHALL have port warp_busy  output  NUM_WARPS  bit w set when any register of warp w is in use.
REQ-014 SHALL have port perf_stalls  output  32  hazard stall cycles (REQ-030).

Function
REQ-015 SHALL hold a NUM_WARPS x NUM_REGS in-use bit table, inuse.
REQ-016 SHALL compute hazard = ibuf_valid && any of inuse[ibuf_wid][rd|rs1|rs2|rs3], read from registered table state only (no same-cycle writeback bypass).
REQ-017 SHALL drive issue_valid = ibuf_valid && !hazard, combinationally.
REQ-018 SHALL drive ibuf_ready = issue_ready && !hazard, combinationally; issue fire = issue_valid && issue_ready.
REQ-019 SHALL, on issue fire with ibuf_wb=1 and ibuf_rd!=0, set inuse[ibuf_wid][ibuf_rd] at next edge.
REQ-020 SHALL, on wb_valid && wb_eop with wb_rd!=0, clear inuse[wb_wid][wb_rd] at next edge; wb_valid with wb_eop=0 changes nothing.
REQ-021 SHALL never set register index 0 of any warp; it always reads as not in use.
REQ-022 SHALL, when set and clear target the same warp/register in one cycle, apply set (set wins); clear affecting a different entry proceeds independently.
REQ-023 SHALL release a register for issue no earlier than the cycle after its eop writeback (1-cycle release latency).
REQ-024 SHALL treat a hazard stall as holding: ibuf_ready=0, no table set, head fields unchanged by protocol.
REQ-025 SHALL drive warp_busy[w] as the registered OR-reduction of inuse[w][*], reflecting table state.
REQ-026 SHALL tolerate wb for a non-set register: clear is a no-op, no error.

Reset
REQ-027 SHALL on reset clear every inuse bit, including mid-operation, with pending writebacks dropped.
REQ-028 SHALL on reset drive warp_busy=0, perf_stalls=0; issue_valid and ibuf_ready then follow REQ-017/018 combinationally from a clear table.
REQ-029 SHALL ignore issue fire and writeback in any cycle where reset is high.

Configuration
REQ-030 SHALL, with macro SCOREBOARD_PERF_EN defined, increment perf_stalls by 1 each non-reset cycle where ibuf_valid && hazard, saturating at 0xFFFFFFFF.
REQ-031 SHALL, without SCOREBOARD_PERF_EN, tie perf_stalls to 0 and synthesize no counter.

Verification
REQ-032 SHALL cover: warp 1 issues wb rd=5 -> next cycle warp 1 head rs1=5 gives issue_valid=0, ibuf_ready=0; eop writeback w1/r5 -> issue_valid=1 exactly one cycle after wb edge.
REQ-033 SHALL cover: warp 0 rd=5 in use, warp 2 head rs2=5 -> issue_valid=1 (per-warp isolation).
REQ-034 SHALL cover: issue wb rd=0 -> inuse unchanged, warp_busy=0, subsequent rs1=0 head issues without stall.
REQ-035 SHALL cover: same-cycle issue fire setting w3/r7 and eop writeback clearing w3/r7 -> r7 remains in use, warp_busy[3]=1.
REQ-036 SHALL cover: non-eop wb w1/r5 then eop wb w1/r5 -> hazard held after first, released after second.
REQ-037 SHALL cover: SCOREBOARD_PERF_EN, 10 stall cycles then reset mid-stall -> perf_stalls=10 before reset, 0 and all warp_busy=0 after.
